nn_frame_streamer: RTL and testbench

//  Upstream feeder for the neural-network core. Host writes (din, w) byte pairs into a

---
 rtl/nn_pkg.sv | 18 +
 rtl/nn_pair_fifo.sv | 46 ++++
 rtl/nn_frame_streamer.sv | 139 +++++++++++++
 tb/tb_nn_frame_streamer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types for the NN frame streamer: byte width, FSM state encoding and
// the (din, w) pair carried through the FIFO.
package nn_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] din;
    logic [BYTE_W-1:0] w;
  } pair_t;

endpackage

// File: rtl/nn_pair_fifo.sv
// Pair FIFO of 2**AW entries; AW+1-bit pointers so full/empty are told apart by the MSB.
// A push while full is only taken when a pop frees the slot in the same cycle.
module nn_pair_fifo
  import nn_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  pair_t       wr_data,
  input  logic        pop,
  output pair_t       rd_data,
  output logic        full,
  output logic [AW:0] level,
  output logic        drop
);

  pair_t       mem [2**AW];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        push_ok;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage needs no reset: resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/nn_frame_streamer.sv
// Buffers host (din, w) pairs and emits whole frames of FRAME_LEN pairs back to back.
// Optional per-frame checksum port chk is built when NN_STREAM_CHECKSUM_EN is defined.
module nn_frame_streamer
  import nn_pkg::*;
#(
  parameter int FRAME_LEN  = 64,
  parameter int AW         = 6,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_din,
  input  logic [BYTE_W-1:0] wr_w,
  input  logic              start,
  output logic              full,
  output logic [AW:0]       level,
  output logic              busy,
  output logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] w,
  output logic              frame_valid,
  output logic              frame_last,
  output logic              err_ovf,
`ifdef NN_STREAM_CHECKSUM_EN
  output logic              err_short,
  output logic [BYTE_W-1:0] chk
`else
  output logic              err_short
`endif
);

  localparam int BW = $clog2(FRAME_LEN + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t          state_reg, state_next;
  logic [BW-1:0]   beat_reg, beat_next;
  logic [GW-1:0]   gap_reg, gap_next;
  logic            short_hit;
  logic            pop;
  logic            last_pop;
  logic            drop;
  pair_t           rd_data;
  pair_t           wr_pair;

  assign wr_pair = '{din: wr_din, w: wr_w};

  nn_pair_fifo #(.AW(AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_en),
    .wr_data (wr_pair),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .level   (level),
    .drop    (drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      beat_reg  <= '0;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      gap_reg   <= gap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    gap_next   = gap_reg;
    short_hit  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (level >= (AW+1)'(FRAME_LEN)) begin
            state_next = ST_STREAM;
            beat_next  = '0;
          end else begin
            short_hit = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        beat_next = beat_reg + 1'b1;
        if (beat_reg == BW'(FRAME_LEN - 1)) begin
          state_next = ST_GAP;
          gap_next   = '0;
        end
      end
      ST_GAP: begin
        if (gap_reg == GW'(GAP_CYCLES - 1)) state_next = ST_IDLE;
        else                                gap_next   = gap_reg + 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pop      = (state_reg == ST_STREAM);
    busy     = (state_reg != ST_IDLE);
    last_pop = pop && (beat_reg == BW'(FRAME_LEN - 1));
  end

  // Network-facing bytes are registered one cycle behind the pop and forced to zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din         <= '0;
      w           <= '0;
      frame_valid <= 1'b0;
      frame_last  <= 1'b0;
      err_ovf     <= 1'b0;
      err_short   <= 1'b0;
    end else begin
      din         <= pop ? rd_data.din : '0;
      w           <= pop ? rd_data.w   : '0;
      frame_valid <= pop;
      frame_last  <= last_pop;
      err_ovf     <= err_ovf | drop;
      err_short   <= err_short | short_hit;
    end
  end

`ifdef NN_STREAM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk <= '0;
    end else if (state_reg == ST_IDLE && state_next == ST_STREAM) begin
      chk <= '0;
    end else if (frame_valid) begin
      chk <= chk + din + w;
    end
  end
`endif

endmodule

// File: tb/tb_nn_frame_streamer.sv
// Directed bench for nn_frame_streamer; the checksum test runs only when
// NN_STREAM_CHECKSUM_EN is defined for both bench and design.
module tb_nn_frame_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_din = 8'h00;
  logic [7:0] wr_w = 8'h00;
  logic       start = 1'b0;
  logic       full;
  logic [6:0] level;
  logic       busy;
  logic [7:0] din;
  logic [7:0] w;
  logic       frame_valid;
  logic       frame_last;
  logic       err_ovf;
  logic       err_short;
`ifdef NN_STREAM_CHECKSUM_EN
  logic [7:0] chk;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  nn_frame_streamer #(.FRAME_LEN(64), .AW(6), .GAP_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_din      (wr_din),
    .wr_w        (wr_w),
    .start       (start),
    .full        (full),
    .level       (level),
    .busy        (busy),
    .din         (din),
    .w           (w),
    .frame_valid (frame_valid),
    .frame_last  (frame_last),
    .err_ovf     (err_ovf),
`ifdef NN_STREAM_CHECKSUM_EN
    .err_short   (err_short),
    .chk         (chk)
`else
    .err_short   (err_short)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] ww, input bit accept);
    wr_en  = 1'b1;
    wr_din = d;
    wr_w   = ww;
    if (accept) exp_q.push_back({d, ww});
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Start a frame and check every beat against the expected queue; optionally
  // push n_push pairs during the first beats (push+pop in the same cycle).
  task automatic run_frame(input int n_push, input bit hold_full);
    logic [15:0] exp_pair;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", {30'd0, busy, frame_valid}, 32'h2);
    for (int b = 0; b < 64; b++) begin
      if (b < n_push) begin
        wr_en  = 1'b1;
        wr_din = 8'(8'h70 + b);
        wr_w   = 8'h07;
        exp_q.push_back({wr_din, wr_w});
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      exp_pair = exp_q.pop_front();
      check($sformatf("beat%0d", b), {14'd0, frame_valid, frame_last, din, w},
            {14'd0, 1'b1, (b == 63), exp_pair});
      if (hold_full && b < n_push) check("level_hold", {25'd0, level}, 32'd64);
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("gap", {14'd0, busy, frame_valid, din, w}, {14'd0, 1'b1, 1'b0, 16'h0000});
    @(negedge clk);
    check("idle", {30'd0, busy, frame_valid}, 32'h0);
    check("level_after", {25'd0, level}, exp_q.size());
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_flags", {26'd0, busy, frame_valid, frame_last, full, err_ovf, err_short}, 32'h0);
    check("rst_level", {25'd0, level}, 32'd0);
    check("rst_bytes", {16'd0, din, w}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Full frame in push order
    for (int i = 0; i < 64; i++) push(8'(i), 8'(-i), 1'b1);
    check("t1_level", {25'd0, level}, 32'd64);
    check("t1_full", {31'd0, full}, 32'd1);
    run_frame(0, 1'b0);

    // Short start
    for (int i = 0; i < 10; i++) push(8'(8'hA0 + i), 8'(i), 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t2_short", {31'd0, err_short}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_level", {25'd0, level}, 32'd10);
    @(negedge clk);
    check("t2_bytes", {15'd0, busy, din, w}, 32'h0);

    // Overflow: 65th pair dropped
    for (int i = 0; i < 54; i++) push(8'(8'h40 + i), 8'(8'hC0 + i), 1'b1);
    check("t3_full", {30'd0, full, err_ovf}, 32'h2);
    check("t3_level64", {25'd0, level}, 32'd64);
    push(8'hEE, 8'hEE, 1'b0);
    check("t3_ovf", {30'd0, full, err_ovf}, 32'h3);
    check("t3_level", {25'd0, level}, 32'd64);

    // Push while full during streaming
    run_frame(5, 1'b1);
    check("t4_ovf_sticky", {31'd0, err_ovf}, 32'd1);

    // Reset mid-frame
    for (int i = 0; i < 59; i++) push(8'(i), 8'h55, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_streaming", {31'd0, frame_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_flags", {26'd0, busy, frame_valid, frame_last, full, err_ovf, err_short}, 32'h0);
    check("t5_level", {25'd0, level}, 32'd0);
    check("t5_bytes", {16'd0, din, w}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_after", {24'd0, level, busy}, 32'h0);

`ifdef NN_STREAM_CHECKSUM_EN
    check("t6_chk_rst", {24'd0, chk}, 32'h0);
    for (int i = 0; i < 64; i++) push(8'h01, 8'h02, 1'b1);
    run_frame(0, 1'b0);
    check("t6_chk", {24'd0, chk}, 32'hC0);
    repeat (3) @(negedge clk);
    check("t6_chk_hold", {24'd0, chk}, 32'hC0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
